alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor of the datapath ALU for the multi-cycle CPU.
//  Single-cycle ops (add/sub/logic/shift/compare) return in 1 cycle; iterative unsigned
//  multiply takes WIDTH cycles. Valid/ready handshakes on both sides allow stalls from issue/writeback.
// PARAMETERS
//  WIDTH   32  operand/result width (>=8, power of 2)
//  SHW     $clog2(WIDTH)  shift-amount width (derived; do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/opcode valid
//  in_ready   out  1      block can accept an operation this cycle
//  opcode     in   6      operation select (table below)
//  a, b       in   WIDTH  operands; shifts use b[SHW-1:0]
//  carry_in   in   1      carry for ADDC
//  out_valid  out  1      result registers valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  result (low word for MULU/quotient for DIVU)
//  result_hi  out  WIDTH  MULU high word / DIVU remainder; 0 otherwise
//  neg_f, zero_f, carry_f, ovf_f  out 1 each  flags, registered with result
//  illegal_op out  1      opcode not decoded (result=0)
// BEHAVIOUR
//  - Opcodes: ADD 000000, SUB 000001, AND 000010, OR 000011, XOR 000100, SLL 000110, SRL 000111,
//    NOR 001001, SRA 001010, SLT 001011, SLTU 001100, MULU 001101, DIVU 001110, ADDC 001111.
//  - Accept = in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  - FSM: IDLE -> (accept MULU/DIVU) BUSY; BUSY counts WIDTH cycles -> load outputs, IDLE.
//    Single-cycle ops load outputs on the accept edge (latency 1). MULU/DIVU latency WIDTH+1.
//  - out_valid set on load; cleared when out_valid && out_ready and no new load same edge;
//    simultaneous drain+load keeps out_valid=1 with new data. Outputs stable while stalled.
//  - Arithmetic: ADD {carry_f,result}=a+b; ADDC adds carry_in; SUB result=a-b, carry_f=borrow (a<b unsigned);
//    ovf_f signed overflow for ADD/ADDC/SUB, else 0; carry_f 0 for non-arith ops.
//  - SLT/SLTU: result={WIDTH-1'b0, lt} signed/unsigned. SRA sign-extends. Shift by >=WIDTH impossible (SHW bits).
//  - MULU: shift-add, 2*WIDTH product -> {result_hi,result}; carry_f=|result_hi; ovf_f=0.
//  - neg_f=result[WIDTH-1], zero_f=(result==0) for every op including MULU low word.
//  - Illegal opcode: single-cycle path, result=0, zero_f=1, illegal_op=1 for that result only.
//  - Reset (any time, incl. BUSY): state IDLE, counters 0, out_valid 0, result/result_hi 0,
//    all flags 0, illegal_op 0; in-flight op discarded. in_ready=1 after reset release.
// CONFIGURATION
//  - ALU_PIPE_DIV_EN defined: DIVU is restoring divide, WIDTH cycles; quotient->result,
//    remainder->result_hi; b==0 -> result all-ones, result_hi=a, ovf_f=1.
//  - Not defined: DIVU decodes as illegal opcode (result 0, illegal_op=1); no divider logic.
// TESTING (WIDTH=32)
//  - ADD a=6,b=10 -> next cycle result=16, flags 0; a=32'h7FFFFFFF,b=1 -> result=32'h80000000, neg_f=1, ovf_f=1.
//  - SUB a=6,b=10 -> result=32'hFFFFFFFC, neg_f=1, carry_f=1, ovf_f=0; SLT a=-1,b=1 -> 1, SLTU -> 0.
//  - SRA a=32'h80000000,b=4 -> 32'hF8000000; SLL a=1,b=31 -> 32'h80000000; ADDC a=b=32'hFFFFFFFF,ci=1 -> result FFFFFFFF, carry_f=1.
//  - MULU a=32'hFFFFFFFF,b=2 -> out_valid after 33 cycles, result_hi=1, result=32'hFFFFFFFE, carry_f=1; in_ready=0 while BUSY.
//  - Backpressure: out_ready=0, issue AND -> result held, in_ready=0 until drain; drain+new op same edge keeps out_valid=1.
//  - Reset asserted mid-MULU -> out_valid=0, in_ready=1 after release; DIVU b=0 -> all-ones/ovf_f=1 (EN) or illegal_op=1 (no EN).

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Define ALU_PIPE_DIV_EN to add a restoring divider on DIVU; without it DIVU decodes as illegal.
//
// state | meaning
// IDLE  | accepting ops; single-cycle results load on the accept edge
// BUSY  | MULU/DIVU iterating one bit per cycle, results load when the counter reaches 0
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             neg_f,
    output logic             zero_f,
    output logic             carry_f,
    output logic             ovf_f,
    output logic             illegal_op
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_AND  = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b000011;
    localparam logic [5:0] OP_XOR  = 6'b000100;
    localparam logic [5:0] OP_SLL  = 6'b000110;
    localparam logic [5:0] OP_SRL  = 6'b000111;
    localparam logic [5:0] OP_NOR  = 6'b001001;
    localparam logic [5:0] OP_SRA  = 6'b001010;
    localparam logic [5:0] OP_SLT  = 6'b001011;
    localparam logic [5:0] OP_SLTU = 6'b001100;
    localparam logic [5:0] OP_MULU = 6'b001101;
    localparam logic [5:0] OP_ADDC = 6'b001111;
`ifdef ALU_PIPE_DIV_EN
    localparam logic [5:0] OP_DIVU = 6'b001110;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           state_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             neg_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             illegal_q;

    logic             accept;
    logic             multi_op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi_d;
    logic [WIDTH-1:0] step_lo_d;

`ifdef ALU_PIPE_DIV_EN
    logic             div_q;
    logic             is_div;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign is_div   = (opcode == OP_DIVU);
    assign multi_op = (opcode == OP_MULU) || is_div;
`else
    assign multi_op = (opcode == OP_MULU);
`endif

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHW-1:0];

    always_comb begin
        sum_w   = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDC: begin
                sum_w   = {1'b0, a} + {1'b0, b} +
                          {{WIDTH{1'b0}}, (opcode == OP_ADDC) && carry_in};
                alu_res = sum_w[MSB:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_SUB: begin
                // bit WIDTH of the widened difference is the unsigned borrow
                sum_w   = {1'b0, a} - {1'b0, b};
                alu_res = sum_w[MSB:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_ill = 1'b1;
        endcase
    end

    // Multiply: product register {acc_hi, acc_lo} starts as {0, b}, one add-and-shift per cycle
    assign mul_sum = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : {WIDTH{1'b0}})};

`ifdef ALU_PIPE_DIV_EN
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in
    assign div_shift = {acc_hi_q, acc_lo_q[MSB]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[MSB:0] - opnd_q;

    always_comb begin
        step_hi_d = mul_sum[WIDTH:1];
        step_lo_d = {mul_sum[0], acc_lo_q[MSB:1]};
        if (div_q) begin
            step_hi_d = div_ge ? div_diff : div_shift[MSB:0];
            step_lo_d = {acc_lo_q[MSB-1:0], div_ge};
        end
    end
`else
    assign step_hi_d = mul_sum[WIDTH:1];
    assign step_lo_d = {mul_sum[0], acc_lo_q[MSB:1]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
`ifdef ALU_PIPE_DIV_EN
            div_q       <= 1'b0;
`endif
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (multi_op) begin
                            state_q  <= S_BUSY;
                            cnt_q    <= SHW'(WIDTH - 1);
                            acc_hi_q <= '0;
`ifdef ALU_PIPE_DIV_EN
                            div_q    <= is_div;
                            acc_lo_q <= is_div ? a : b;
                            opnd_q   <= is_div ? b : a;
`else
                            acc_lo_q <= b;
                            opnd_q   <= a;
`endif
                        end else begin
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            result_hi_q <= '0;
                            neg_q       <= alu_res[MSB];
                            zero_q      <= (alu_res == '0);
                            carry_q     <= alu_c;
                            ovf_q       <= alu_v;
                            illegal_q   <= alu_ill;
                        end
                    end
                end
                S_BUSY: begin
                    acc_hi_q <= step_hi_d;
                    acc_lo_q <= step_lo_d;
                    if (cnt_q == '0) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        result_q    <= step_lo_d;
                        result_hi_q <= step_hi_d;
                        neg_q       <= step_lo_d[MSB];
                        zero_q      <= (step_lo_d == '0);
                        illegal_q   <= 1'b0;
`ifdef ALU_PIPE_DIV_EN
                        carry_q     <= !div_q && (|step_hi_d);
                        ovf_q       <= div_q && (opnd_q == '0);
`else
                        carry_q     <= |step_hi_d;
                        ovf_q       <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - SHW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign result_hi  = result_hi_q;
    assign neg_f      = neg_q;
    assign zero_f     = zero_q;
    assign carry_f    = carry_q;
    assign ovf_f      = ovf_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (WIDTH=32) against an arithmetic model.
// Honours ALU_PIPE_DIV_EN in the model the same way the design does.
module tb_alu_pipe;
    localparam int W = 32;

    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, XOR_ = 6'd4;
    localparam logic [5:0] SLL = 6'd6, SRL = 6'd7, NOR_ = 6'd9, SRA = 6'd10, SLT = 6'd11;
    localparam logic [5:0] SLTU = 6'd12, MULU = 6'd13, DIVU = 6'd14, ADDC = 6'd15;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         neg_f, zero_f, carry_f, ovf_f, illegal_op;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .neg_f(neg_f), .zero_f(zero_f), .carry_f(carry_f), .ovf_f(ovf_f),
        .illegal_op(illegal_op)
    );

    // flags packed as {neg, zero, carry, ovf, illegal}
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [4:0]  fl;
    } exp_t;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit is_multi(input logic [5:0] op);
`ifdef ALU_PIPE_DIV_EN
        return (op == MULU) || (op == DIVU);
`else
        return (op == MULU);
`endif
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                   input logic ci);
        longint sx, sy, s;
        logic [63:0] u;
        logic [31:0] r, h;
        logic c, v, il;
        exp_t e;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '0; h = '0; c = 1'b0; v = 1'b0; il = 1'b0;
        case (op)
            ADD: begin
                u = 64'(x) + 64'(y); r = u[31:0]; c = u[32];
                s = sx + sy; v = (s > SMAX) || (s < SMIN);
            end
            ADDC: begin
                u = 64'(x) + 64'(y) + 64'(ci); r = u[31:0]; c = u[32];
                s = sx + sy + longint'(ci); v = (s > SMAX) || (s < SMIN);
            end
            SUB: begin
                r = x - y; c = (x < y);
                s = sx - sy; v = (s > SMAX) || (s < SMIN);
            end
            AND_: r = x & y;
            OR_:  r = x | y;
            XOR_: r = x ^ y;
            NOR_: r = ~(x | y);
            SLL:  r = x << y[4:0];
            SRL:  r = x >> y[4:0];
            SRA:  r = 32'(sx / (longint'(1) <<< y[4:0]) - ((sx < 0 && (sx % (longint'(1) <<< y[4:0])) != 0) ? 1 : 0));
            SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
            SLTU: r = (x < y) ? 32'd1 : 32'd0;
            MULU: begin
                u = 64'(x) * 64'(y); r = u[31:0]; h = u[63:32]; c = (h != 0);
            end
            DIVU: begin
`ifdef ALU_PIPE_DIV_EN
                if (y == 0) begin r = 32'hFFFFFFFF; h = x; v = 1'b1; end
                else begin r = x / y; h = x % y; end
`else
                il = 1'b1;
`endif
            end
            default: il = 1'b1;
        endcase
        e.res = r;
        e.hi  = h;
        e.fl  = {r[31], (r == 0), c, v, il};
        return e;
    endfunction

    task automatic run_op(input string name, input logic [5:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci, input int stall);
        exp_t e;
        int   guard;
        int   lat;
        int   exp_lat;
        e = model(op, av, bv, ci);
        exp_lat = is_multi(op) ? W + 1 : 1;
        @(negedge clk);
        opcode = op; a = av; b = bv; carry_in = ci;
        in_valid = 1'b1; out_ready = (stall == 0);
        guard = 0;
        while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
        chk({name, ".rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (exp_lat > 1 && lat == 5) chk({name, ".busy_rdy"}, 64'(in_ready), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({name, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({name, ".res"}, 64'(result), 64'(e.res));
        chk({name, ".hi"}, 64'(result_hi), 64'(e.hi));
        chk({name, ".flags"}, 64'({neg_f, zero_f, carry_f, ovf_f, illegal_op}), 64'(e.fl));
        repeat (stall) begin
            @(posedge clk); #1;
            chk({name, ".hold"}, 64'({out_valid, result}), 64'({1'b1, e.res}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, ".drain"}, 64'(out_valid), 64'd0);
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 15));
            1: case ($urandom_range(0, 3))
                   0: return 32'h00000000;
                   1: return 32'h7FFFFFFF;
                   2: return 32'h80000000;
                   default: return 32'hFFFFFFFF;
               endcase
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [17];
        exp_t       e;
        ops = '{ADD, SUB, AND_, OR_, XOR_, SLL, SRL, NOR_, SRA, SLT, SLTU, MULU, DIVU, ADDC,
                6'd5, 6'd8, 6'd63};

        in_valid = 1'b0; opcode = '0; a = '0; b = '0; carry_in = 1'b0; out_ready = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.res", 64'({result, result_hi}), 64'd0);
        chk("rst.flags", 64'({neg_f, zero_f, carry_f, ovf_f, illegal_op}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.in_ready", 64'(in_ready), 64'd1);

        run_op("add", ADD, 32'd6, 32'd10, 1'b0, 0);
        chk("add.lit", 64'(result), 64'd16);
        run_op("add_ovf", ADD, 32'h7FFFFFFF, 32'd1, 1'b0, 0);
        run_op("sub", SUB, 32'd6, 32'd10, 1'b0, 0);
        run_op("slt", SLT, 32'hFFFFFFFF, 32'd1, 1'b0, 0);
        run_op("sltu", SLTU, 32'hFFFFFFFF, 32'd1, 1'b0, 0);
        run_op("sra", SRA, 32'h80000000, 32'd4, 1'b0, 0);
        run_op("sll", SLL, 32'd1, 32'd31, 1'b0, 0);
        run_op("addc", ADDC, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0);
        run_op("mulu", MULU, 32'hFFFFFFFF, 32'd2, 1'b0, 0);
        chk("mulu.lit", 64'({result_hi, result}), 64'h00000001_FFFFFFFE);
        run_op("divu", DIVU, 32'd100, 32'd7, 1'b0, 0);
        run_op("divu0", DIVU, 32'd12345, 32'd0, 1'b0, 0);
        run_op("illegal", 6'd63, 32'd5, 32'd5, 1'b0, 2);

        // output stall, then drain and a new load on the same edge
        @(negedge clk);
        opcode = AND_; a = 32'hF0F01234; b = 32'h0FF0FF00; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = model(AND_, 32'hF0F01234, 32'h0FF0FF00, 1'b0);
        chk("bp.valid", 64'(out_valid), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp.hold", 64'({out_valid, result}), 64'({1'b1, e.res}));
            chk("bp.rdy", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        opcode = XOR_; a = 32'h12345678; b = 32'hFFFF0000; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bp.rdy_drain", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = model(XOR_, 32'h12345678, 32'hFFFF0000, 1'b0);
        chk("bp.reload", 64'({out_valid, result}), 64'({1'b1, e.res}));
        @(posedge clk); #1;
        chk("bp.drain", 64'(out_valid), 64'd0);

        // reset in the middle of a multiply discards it
        @(negedge clk);
        opcode = MULU; a = 32'd1234; b = 32'd5678; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rstbusy.valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstbusy.rdy", 64'(in_ready), 64'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("rstbusy.quiet", 64'({out_valid, result}), 64'd0);
        run_op("post_rst", ADD, 32'd3, 32'd4, 1'b0, 0);

        for (int i = 0; i < 250; i++) begin
            logic [5:0] op;
            int stall;
            op = ops[$urandom_range(0, 16)];
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op("rnd", op, rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)), stall);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
